// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: constants shared by the execute stage and its ALU.
//   ALU_OP_*     : 2-bit ALU operation class carried from decode
//   F3_*         : funct3 encodings for ALU operations and branch compares
//   MEM_REG_PC_* : writeback-select encodings carried to the MEM/WB stages
package ex_mem_stage_pkg;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_LUI    = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] MEM_REG_PC_ALU = 2'b00;
  localparam logic [1:0] MEM_REG_PC_MEM = 2'b01;
  localparam logic [1:0] MEM_REG_PC_PC  = 2'b10;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// ex_mem_stage_alu: combinational execute-stage ALU and branch comparator.
//   a, b        : operands (b is already muxed between rs2 and the immediate)
//   cmp_b       : forwarded rs2, the second operand of branch compares
//   alu_op, f3, f7_bit, alu_src : operation select
//   result      : ALU result
//   branch_cond : branch comparison outcome selected by f3
module ex_mem_stage_alu
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] cmp_b,
  input  logic [XLEN-1:0] imm32,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      f3,
  input  logic            f7_bit,
  input  logic            alu_src,
  output logic [XLEN-1:0] result,
  output logic            branch_cond
);

  logic [4:0] shamt_s;
  assign shamt_s = b[4:0];

  // ALU result: operation class first, then funct3 decode for R/I-type ops
  always_comb begin
    result = {XLEN{1'b0}};
    case (alu_op)
      ALU_OP_ADD:    result = a + b;
      ALU_OP_BRANCH: result = a - b;
      ALU_OP_LUI:    result = imm32;
      ALU_OP_FUNCT: begin
        case (f3)
          // Immediate forms never subtract, so f7_bit only matters for reg-reg
          F3_ADD_SUB: begin
            if (f7_bit && !alu_src) result = a - b;
            else                    result = a + b;
          end
          F3_SLL:  result = a << shamt_s;
          F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
          F3_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
          F3_XOR:  result = a ^ b;
          F3_SRL_SRA: begin
            if (f7_bit) result = $signed(a) >>> shamt_s;
            else        result = a >> shamt_s;
          end
          F3_OR:   result = a | b;
          F3_AND:  result = a & b;
          default: result = {XLEN{1'b0}};
        endcase
      end
      default: result = {XLEN{1'b0}};
    endcase
  end

  // Branch condition; f3 010/011 are not branch encodings and never take
  always_comb begin
    branch_cond = 1'b0;
    case (f3)
      F3_BEQ:  branch_cond = (a == cmp_b);
      F3_BNE:  branch_cond = (a != cmp_b);
      F3_BLT:  branch_cond = ($signed(a) < $signed(cmp_b));
      F3_BGE:  branch_cond = ($signed(a) >= $signed(cmp_b));
      F3_BLTU: branch_cond = (a < cmp_b);
      F3_BGEU: branch_cond = (a >= cmp_b);
      default: branch_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus the EX/MEM pipeline register.
//   clk, reset (async, active-low), stall (hold register), flush (squash EX)
//   ID/EX inputs : register indices, control bits, ALU select, PC and data
//   MEM/WB inputs: mem_wb_reg_write, mem_wb_rd, mem_wb_data for forwarding
//   redirect_valid/redirect_pc : combinational PC redirect for taken
//                                branches, jal and jalr
//   *_q          : EX/MEM register outputs for the MEM stage
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            jl,
  input  logic            jlr,
  input  logic [1:0]      mem_reg_pc,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic            f7_bit,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] pc_inc,
  input  logic [XLEN-1:0] pc_original,
  input  logic [XLEN-1:0] read_data_1,
  input  logic [XLEN-1:0] read_data_2,
  input  logic [XLEN-1:0] imm32,
  input  logic            mem_wb_reg_write,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            reg_write_q,
  output logic            mem_read_q,
  output logic            mem_write_q,
  output logic [1:0]      mem_reg_pc_q,
  output logic [4:0]      rd_q,
  output logic [2:0]      f3_q,
  output logic [XLEN-1:0] alu_result_q,
  output logic [XLEN-1:0] store_data_q,
  output logic [XLEN-1:0] pc_inc_q
);

  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] alu_result_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic            branch_cond_s;
  logic            ex_hit_rs1_s;
  logic            ex_hit_rs2_s;
  logic            wb_hit_rs1_s;
  logic            wb_hit_rs2_s;

  // x0 is hardwired zero, so a write to it must never be forwarded
  assign ex_hit_rs1_s = reg_write_q && (rd_q != 5'd0) && (rd_q == rs1);
  assign ex_hit_rs2_s = reg_write_q && (rd_q != 5'd0) && (rd_q == rs2);
  assign wb_hit_rs1_s = mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs1);
  assign wb_hit_rs2_s = mem_wb_reg_write && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs2);

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_rs1_s = read_data_1;
    fwd_rs2_s = read_data_2;
    if (ex_hit_rs1_s)      fwd_rs1_s = alu_result_q;
    else if (wb_hit_rs1_s) fwd_rs1_s = mem_wb_data;
    else                   fwd_rs1_s = read_data_1;
    if (ex_hit_rs2_s)      fwd_rs2_s = alu_result_q;
    else if (wb_hit_rs2_s) fwd_rs2_s = mem_wb_data;
    else                   fwd_rs2_s = read_data_2;
  end

  assign op_b_s = alu_src ? imm32 : fwd_rs2_s;

  ex_mem_stage_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a           (fwd_rs1_s),
    .b           (op_b_s),
    .cmp_b       (fwd_rs2_s),
    .imm32       (imm32),
    .alu_op      (alu_op),
    .f3          (f3),
    .f7_bit      (f7_bit),
    .alu_src     (alu_src),
    .result      (alu_result_s),
    .branch_cond (branch_cond_s)
  );

  assign jalr_sum_s = fwd_rs1_s + imm32;

  // PC redirect; deliberately not gated by stall, the hazard unit owns that
  always_comb begin
    redirect_valid = !flush && ((branch && branch_cond_s) || jl || jlr);
    if (jlr) redirect_pc = {jalr_sum_s[XLEN-1:1], 1'b0};
    else     redirect_pc = pc_original + imm32;
  end

  // EX/MEM register: stall holds everything, flush squashes only the
  // side-effecting control bits while data still loads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_reg_pc_q <= MEM_REG_PC_ALU;
      rd_q         <= 5'd0;
      f3_q         <= 3'd0;
      alu_result_q <= {XLEN{1'b0}};
      store_data_q <= {XLEN{1'b0}};
      pc_inc_q     <= {XLEN{1'b0}};
    end else if (stall) begin
      reg_write_q  <= reg_write_q;
      mem_read_q   <= mem_read_q;
      mem_write_q  <= mem_write_q;
      mem_reg_pc_q <= mem_reg_pc_q;
      rd_q         <= rd_q;
      f3_q         <= f3_q;
      alu_result_q <= alu_result_q;
      store_data_q <= store_data_q;
      pc_inc_q     <= pc_inc_q;
    end else begin
      reg_write_q  <= reg_write && !flush;
      mem_read_q   <= mem_read && !flush;
      mem_write_q  <= mem_write && !flush;
      mem_reg_pc_q <= mem_reg_pc;
      rd_q         <= rd;
      f3_q         <= f3;
      alu_result_q <= alu_result_s;
      store_data_q <= fwd_rs2_s;
      pc_inc_q     <= pc_inc;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scenarios plus randomized traffic for
// ex_mem_stage, checked against a behavioural model of the stage.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [4:0]  rs1, rs2, rd, mem_wb_rd;
  logic        reg_write, mem_read, mem_write, branch, jl, jlr, alu_src, f7_bit;
  logic        mem_wb_reg_write;
  logic [1:0]  mem_reg_pc, alu_op;
  logic [2:0]  f3;
  logic [31:0] pc_inc, pc_original, read_data_1, read_data_2, imm32, mem_wb_data;
  logic        redirect_valid, reg_write_q, mem_read_q, mem_write_q;
  logic [31:0] redirect_pc, alu_result_q, store_data_q, pc_inc_q;
  logic [1:0]  mem_reg_pc_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;

  int checks = 0;
  int failures = 0;

  // Model of the EX/MEM register contents
  logic        m_rw, m_mr, m_mw;
  logic [1:0]  m_mrp;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_sd, m_pci;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jl(jl), .jlr(jlr), .mem_reg_pc(mem_reg_pc),
    .alu_src(alu_src), .alu_op(alu_op), .f7_bit(f7_bit), .f3(f3),
    .pc_inc(pc_inc), .pc_original(pc_original),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .imm32(imm32),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .reg_write_q(reg_write_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
    .mem_reg_pc_q(mem_reg_pc_q), .rd_q(rd_q), .f3_q(f3_q),
    .alu_result_q(alu_result_q), .store_data_q(store_data_q), .pc_inc_q(pc_inc_q)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value an operand resolves to, by the forwarding rules
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] file_val);
    if (m_rw && m_rd != 5'd0 && m_rd == idx) return m_alu;
    if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == idx) return mem_wb_data;
    return file_val;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32'd32);
    sa = a;
    if (alu_op == 2'd0) return a + b;
    if (alu_op == 2'd1) return a - b;
    if (alu_op == 2'd3) return imm32;
    case (f3)
      3'd0: return (f7_bit && !alu_src) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (f7_bit) return 32'(sa >>> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic taken_ref(input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check redirect against current inputs, then register outputs
  task automatic step();
    logic [31:0] a, b, res, exp_pc;
    logic        exp_valid;
    if (!reset) begin
      m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_mrp = 2'd0; m_rd = 5'd0;
      m_f3 = 3'd0; m_alu = 32'd0; m_sd = 32'd0; m_pci = 32'd0;
    end
    a = operand(rs1, read_data_1);
    b = operand(rs2, read_data_2);
    res = alu_ref(a, alu_src ? imm32 : b);
    exp_valid = !flush && ((branch && taken_ref(a, b)) || jl || jlr);
    exp_pc = jlr ? ((a + imm32) & 32'hFFFF_FFFE) : (pc_original + imm32);
    #1;
    check_value("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_valid});
    check_value("redirect_pc", redirect_pc, exp_pc);
    @(posedge clk);
    #1;
    if (reset && !stall) begin
      m_rw = reg_write && !flush; m_mr = mem_read && !flush; m_mw = mem_write && !flush;
      m_mrp = mem_reg_pc; m_rd = rd; m_f3 = f3; m_alu = res; m_sd = b; m_pci = pc_inc;
    end
    check_value("reg_write_q", {31'd0, reg_write_q}, {31'd0, m_rw});
    check_value("mem_read_q", {31'd0, mem_read_q}, {31'd0, m_mr});
    check_value("mem_write_q", {31'd0, mem_write_q}, {31'd0, m_mw});
    check_value("mem_reg_pc_q", {30'd0, mem_reg_pc_q}, {30'd0, m_mrp});
    check_value("rd_q", {27'd0, rd_q}, {27'd0, m_rd});
    check_value("f3_q", {29'd0, f3_q}, {29'd0, m_f3});
    check_value("alu_result_q", alu_result_q, m_alu);
    check_value("store_data_q", store_data_q, m_sd);
    check_value("pc_inc_q", pc_inc_q, m_pci);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
    jl = 1'b0; jlr = 1'b0; mem_reg_pc = 2'd0; alu_src = 1'b0; alu_op = 2'd0;
    f7_bit = 1'b0; f3 = 3'd0; pc_inc = 32'd0; pc_original = 32'd0;
    read_data_1 = 32'd0; read_data_2 = 32'd0; imm32 = 32'd0;
    mem_wb_reg_write = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 32'd0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #1;
    // Reset held with live control on the inputs
    reg_write = 1'b1; rd = 5'd5; pc_inc = 32'h44;
    repeat (2) step();
    check_value("rst_reg_write_q", {31'd0, reg_write_q}, 32'd0);
    check_value("rst_rd_q", {27'd0, rd_q}, 32'd0);
    reset = 1'b1;
    step();
    check_value("post_rst_rd_q", {27'd0, rd_q}, 32'd5);

    // EX/MEM forwarding beats MEM/WB
    clear_inputs();
    reg_write = 1'b1; rd = 5'd3; alu_src = 1'b1; imm32 = 32'd10;
    step();
    mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'd99;
    rs1 = 5'd3; read_data_1 = 32'd0; imm32 = 32'd1; rd = 5'd4;
    step();
    check_value("fwd_priority", alu_result_q, 32'd11);

    // Writes to x0 are never forwarded
    clear_inputs();
    reg_write = 1'b1; rd = 5'd0; alu_op = 2'd3; imm32 = 32'd7;
    step();
    check_value("x0_setup", alu_result_q, 32'd7);
    alu_op = 2'd0; alu_src = 1'b1; imm32 = 32'd5;
    mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd0; mem_wb_data = 32'd99;
    step();
    check_value("x0_guard", alu_result_q, 32'd5);

    // blt taken on signed compare, bltu not taken on the same operands
    clear_inputs();
    branch = 1'b1; f3 = 3'd4; rs1 = 5'd1; rs2 = 5'd2; alu_op = 2'd1;
    read_data_1 = 32'hFFFF_FFFF; read_data_2 = 32'd1;
    pc_original = 32'h100; imm32 = 32'h20;
    #1;
    check_value("blt_valid", {31'd0, redirect_valid}, 32'd1);
    check_value("blt_pc", redirect_pc, 32'h120);
    step();
    f3 = 3'd6;
    #1;
    check_value("bltu_valid", {31'd0, redirect_valid}, 32'd0);
    step();

    // jalr clears bit 0 of the target; flush suppresses redirect and write
    clear_inputs();
    jlr = 1'b1; rs1 = 5'd1; read_data_1 = 32'h203; imm32 = 32'd4; reg_write = 1'b1; rd = 5'd1;
    #1;
    check_value("jalr_valid", {31'd0, redirect_valid}, 32'd1);
    check_value("jalr_pc", redirect_pc, 32'h206);
    flush = 1'b1;
    #1;
    check_value("jalr_flush_valid", {31'd0, redirect_valid}, 32'd0);
    step();
    check_value("jalr_flush_rw", {31'd0, reg_write_q}, 32'd0);

    // Stall wins over flush; dropping stall lets the flush take effect
    clear_inputs();
    reg_write = 1'b1; rd = 5'd9; pc_inc = 32'h1000;
    step();
    stall = 1'b1; flush = 1'b1; rd = 5'd12; pc_inc = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("stall_rd", {27'd0, rd_q}, 32'd9);
      check_value("stall_rw", {31'd0, reg_write_q}, 32'd1);
    end
    stall = 1'b0;
    step();
    check_value("unstall_rw", {31'd0, reg_write_q}, 32'd0);
    check_value("unstall_rd", {27'd0, rd_q}, 32'd12);

    // Randomized traffic with frequent register-index collisions
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 5) == 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
      reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      mem_wb_reg_write = 1'($urandom);
      branch = 1'($urandom);
      jl = ($urandom_range(0, 7) == 0); jlr = ($urandom_range(0, 7) == 0);
      mem_reg_pc = 2'($urandom); alu_src = 1'($urandom); alu_op = 2'($urandom);
      f7_bit = 1'($urandom); f3 = 3'($urandom);
      pc_inc = $urandom; pc_original = $urandom; imm32 = $urandom;
      read_data_1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      read_data_2 = ($urandom_range(0, 3) == 0) ? read_data_1 : $urandom;
      mem_wb_data = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
